load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Executes the memory side of loads and stores selected by the control unit's memWrite/loadCtrl/storeCtrl outputs.
- Issues a single-outstanding request to the data-memory port over a req/gnt/rvalid handshake.
- Forms byte enables and lane-aligned write data; returns sign- or zero-extended load data.
- Sits between the execute stage (ALU address, rs2 data) and the data memory, and holds the core with lsuStall until the access completes.

Parameters:
- ADDR_WIDTH, 32, byte-address width of address and dAddr.
- TIMEOUT, 255, maximum cycles spent in REQ or WAIT before a bus error is raised; 8-bit counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- memRead  in  1  load requested this cycle (resultSource selects memory).
- memWrite  in  1  store requested this cycle.
- loadCtrl  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- storeCtrl  in  2  00 SB, 01 SH, 10 SW.
- address  in  ADDR_WIDTH  byte address from the ALU.
- writeData  in  32  store source (rs2).
- readData  out  32  extended load result; valid when done=1.
- done  out  1  one-cycle completion pulse.
- lsuStall  out  1  freeze the pipeline.
- misaligned  out  1  one-cycle alignment-fault pulse.
- busError  out  1  one-cycle timeout pulse.
- dReq  out  1  memory request.
- dWe  out  1  1 = write.
- dAddr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0).
- dBe  out  4  byte enables.
- dWdata  out  32  lane-shifted store data.
- dGnt  in  1  request accepted.
- dRvalid  in  1  read data valid.
- dRdata  in  32  read data word.

Behaviour:
- Reset values (synchronous, rst_n=0 at a clk edge): state IDLE; every registered output and dAddr/dBe/dWdata 0; timeout counter 0. Applies mid-transaction too: the request is dropped, and any later dGnt/dRvalid seen in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Op = memWrite | memRead. memWrite has priority if both are asserted.
  - Alignment check: halfword needs address[0]=0; word needs address[1:0]=00. Reserved encodings (loadCtrl 011/11x, storeCtrl 11) count as misaligned.
  - Misaligned op: pulse misaligned next cycle; no request; stay IDLE; lsuStall=0.
  - Aligned op: register dAddr={address[ADDR_WIDTH-1:2],2'b00}, dWe, dBe, dWdata, load type and address[1:0]; go to REQ.
- Byte enables and store data:
  - SB: dBe=0001<<a[1:0]; dWdata = byte replicated ×4.
  - SH: dBe=0011<<a[1:0]; dWdata = halfword replicated ×2.
  - SW: dBe=1111.
  - Loads: dBe as the matching store width.
- REQ:
  - dReq=1 and address/data held stable until dGnt.
  - dGnt with store → DONE.
  - dGnt with load → WAIT, unless dRvalid is also 1 in that cycle; then capture and go to DONE.
- WAIT: on dRvalid, select the lane by the stored a[1:0], extend, register into readData → DONE.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- DONE: done=1 for one cycle; readData holds its value until the next load completes; → IDLE.
- Timeout:
  - The counter clears on entering REQ and increments in REQ and WAIT.
  - Reaching TIMEOUT → DONE with busError=1 and done=1; readData=0 for loads; dReq dropped.
- lsuStall = (memRead|memWrite) & aligned & state≠DONE, combinational. The issuing instruction is therefore held until the DONE cycle.
- Latency: with zero-wait memory (gnt immediate, rvalid next cycle), a store completes in 3 cycles and a load in 4 (IDLE→REQ→WAIT→DONE).
- A back-to-back op presented in the cycle after DONE is accepted normally.

Decomposition:
- Shared package:
  - loadCtrl and storeCtrl encodings (LSU_LB..LSU_LHU, LSU_SB..LSU_SW).
  - State enum.
  - Alignment-check function.
- Sub-module load_extend (combinational): lane select plus sign/zero extension. Reused by the bench reference model.

Test Plan:
- SW address 0x100, data 0xDEADBEEF, gnt immediate → dAddr=0x100, dBe=1111, dWe=1, done in cycle 3, lsuStall high for 2 cycles.
- SB address 0x203, data 0x000000A5 → dAddr=0x200, dBe=1000, dWdata=0xA5A5A5A5.
- LB address 0x302, dRdata=0x1280FF00 → readData=0xFFFFFF80; the same access with LBU → 0x00000080; LH at 0x302 → 0x00001280.
- LW address 0x101 → misaligned pulse, dReq never asserted, lsuStall=0. LH at 0x103 → same result.
- Load with dGnt withheld for 5 cycles, then dRvalid 3 cycles later → dReq held 6 cycles with stable dAddr, done on the cycle after dRvalid. Repeat with TIMEOUT=8 and no dRvalid → busError=1, readData=0.
- rst_n low during WAIT → next cycle IDLE, dReq=0; a stray dRvalid afterwards produces no done.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings, state enum and alignment helpers for the LSU
package load_store_unit_pkg;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;

  localparam logic [1:0] LSU_SB = 2'b00;
  localparam logic [1:0] LSU_SH = 2'b01;
  localparam logic [1:0] LSU_SW = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} lsu_size_t;

  function automatic lsu_size_t access_size(input logic is_store, input logic [2:0] lctrl,
                                            input logic [1:0] sctrl);
    if (is_store) begin
      case (sctrl)
        LSU_SB:  return SZ_BYTE;
        LSU_SH:  return SZ_HALF;
        LSU_SW:  return SZ_WORD;
        default: return SZ_BAD;
      endcase
    end
    case (lctrl)
      LSU_LB, LSU_LBU: return SZ_BYTE;
      LSU_LH, LSU_LHU: return SZ_HALF;
      LSU_LW:          return SZ_WORD;
      default:         return SZ_BAD;
    endcase
  endfunction

  // Reserved encodings come back as SZ_BAD and are therefore treated as misaligned.
  function automatic logic is_aligned(input lsu_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~a[0];
      SZ_WORD: return (a == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input lsu_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// rtl/load_store_unit_load_extend.sv - lane select and sign/zero extension of a read word
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  lctrl,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lctrl)
      LSU_LB:  data = {{24{b[7]}}, b};
      LSU_LH:  data = {{16{h[15]}}, h};
      LSU_LBU: data = {24'd0, b};
      LSU_LHU: data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit on a req/gnt/rvalid data port
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            loadCtrl,
  input  logic [1:0]            storeCtrl,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  output logic                  done,
  output logic                  lsuStall,
  output logic                  misaligned,
  output logic                  busError,
  output logic                  dReq,
  output logic                  dWe,
  output logic [ADDR_WIDTH-1:0] dAddr,
  output logic [3:0]            dBe,
  output logic [31:0]           dWdata,
  input  logic                  dGnt,
  input  logic                  dRvalid,
  input  logic [31:0]           dRdata
);

  localparam logic [7:0] TLIMIT = 8'(TIMEOUT);

  lsu_state_t  state;
  logic [7:0]  tcount;
  logic [2:0]  ld_ctrl;
  logic [1:0]  lane;
  lsu_size_t   size;
  logic        is_op;
  logic        aligned;
  logic        timeout_hit;
  logic [31:0] store_word;
  logic [31:0] ext_data;

  assign is_op       = memRead | memWrite;
  assign size        = access_size(memWrite, loadCtrl, storeCtrl);
  assign aligned     = is_aligned(size, address[1:0]);
  assign lsuStall    = is_op & aligned & (state != ST_DONE);
  assign timeout_hit = (tcount + 8'd1) == TLIMIT;

  always_comb begin
    case (size)
      SZ_BYTE: store_word = {4{writeData[7:0]}};
      SZ_HALF: store_word = {2{writeData[15:0]}};
      default: store_word = writeData;
    endcase
  end

  load_extend u_extend (
    .rdata (dRdata),
    .lane  (lane),
    .lctrl (ld_ctrl),
    .data  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tcount     <= '0;
      ld_ctrl    <= '0;
      lane       <= '0;
      readData   <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      busError   <= 1'b0;
      dReq       <= 1'b0;
      dWe        <= 1'b0;
      dAddr      <= '0;
      dBe        <= '0;
      dWdata     <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      busError   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_op && aligned) begin
            state   <= ST_REQ;
            dReq    <= 1'b1;
            dWe     <= memWrite;
            dAddr   <= {address[ADDR_WIDTH-1:2], 2'b00};
            dBe     <= byte_enable(size, address[1:0]);
            dWdata  <= memWrite ? store_word : 32'd0;
            ld_ctrl <= loadCtrl;
            lane    <= address[1:0];
            tcount  <= '0;
          end else if (is_op) begin
            misaligned <= 1'b1;
          end
        end
        ST_REQ: begin
          tcount <= tcount + 8'd1;
          if (dGnt) begin
            dReq <= 1'b0;
            if (dWe) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (dRvalid) begin
              readData <= ext_data;
              state    <= ST_DONE;
              done     <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end else if (timeout_hit) begin
            dReq     <= 1'b0;
            state    <= ST_DONE;
            done     <= 1'b1;
            busError <= 1'b1;
            if (!dWe) readData <= '0;
          end
        end
        ST_WAIT: begin
          tcount <= tcount + 8'd1;
          if (dRvalid) begin
            readData <= ext_data;
            state    <= ST_DONE;
            done     <= 1'b1;
          end else if (timeout_hit) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            busError <= 1'b1;
            readData <= '0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRead, memWrite, dGnt, dRvalid;
  logic [2:0]  loadCtrl;
  logic [1:0]  storeCtrl;
  logic [31:0] address, writeData, dRdata;

  logic [31:0] a_readData, b_readData, a_dAddr, b_dAddr, a_dWdata, b_dWdata;
  logic [3:0]  a_dBe, b_dBe;
  logic        a_done, b_done, a_lsuStall, b_lsuStall, a_mis, b_mis, a_bus, b_bus;
  logic        a_dReq, b_dReq, a_dWe, b_dWe;

  logic        sel8;
  logic [31:0] readData, dAddr, dWdata;
  logic [3:0]  dBe;
  logic        done, lsuStall, misaligned, busError, dReq, dWe;

  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        s_we, s_bus;

  int tests = 0;
  int fails = 0;
  int lat, stalls, reqs;
  logic stable;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .loadCtrl(loadCtrl), .storeCtrl(storeCtrl), .address(address), .writeData(writeData),
    .readData(a_readData), .done(a_done), .lsuStall(a_lsuStall), .misaligned(a_mis),
    .busError(a_bus), .dReq(a_dReq), .dWe(a_dWe), .dAddr(a_dAddr), .dBe(a_dBe),
    .dWdata(a_dWdata), .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata)
  );

  load_store_unit #(.TIMEOUT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .loadCtrl(loadCtrl), .storeCtrl(storeCtrl), .address(address), .writeData(writeData),
    .readData(b_readData), .done(b_done), .lsuStall(b_lsuStall), .misaligned(b_mis),
    .busError(b_bus), .dReq(b_dReq), .dWe(b_dWe), .dAddr(b_dAddr), .dBe(b_dBe),
    .dWdata(b_dWdata), .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata)
  );

  always_comb begin
    readData   = sel8 ? b_readData : a_readData;
    dAddr      = sel8 ? b_dAddr    : a_dAddr;
    dWdata     = sel8 ? b_dWdata   : a_dWdata;
    dBe        = sel8 ? b_dBe      : a_dBe;
    done       = sel8 ? b_done     : a_done;
    lsuStall   = sel8 ? b_lsuStall : a_lsuStall;
    misaligned = sel8 ? b_mis      : a_mis;
    busError   = sel8 ? b_bus      : a_bus;
    dReq       = sel8 ? b_dReq     : a_dReq;
    dWe        = sel8 ? b_dWe      : a_dWe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; memRead = 0; memWrite = 0; dGnt = 0; dRvalid = 0;
    loadCtrl = '0; storeCtrl = '0; address = '0; writeData = '0; dRdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Memory model: grant after gnt_wait request cycles, rvalid rv_wait cycles after grant (<0: never).
  task automatic access(input logic st, input logic [2:0] lc, input logic [1:0] sc,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int gnt_wait, input int rv_wait);
    int gcyc;
    logic granted;
    lat = -1; stalls = 0; reqs = 0; stable = 1'b1; granted = 1'b0; gcyc = 0;
    memWrite = st; memRead = ~st; loadCtrl = lc; storeCtrl = sc;
    address = a; writeData = wd; dRdata = rd;
    for (int n = 1; n <= 400; n++) begin
      dGnt = 1'b0; dRvalid = 1'b0;
      if (dReq) begin
        reqs++;
        if (reqs == 1) begin
          s_addr = dAddr; s_be = dBe; s_wdata = dWdata; s_we = dWe;
        end else if (dAddr !== s_addr || dBe !== s_be || dWdata !== s_wdata) begin
          stable = 1'b0;
        end
        if (!granted && reqs - 1 == gnt_wait) begin
          dGnt = 1'b1; granted = 1'b1; gcyc = n;
        end
      end
      if (!st && granted && rv_wait >= 0 && n - gcyc == rv_wait) dRvalid = 1'b1;
      @(negedge clk);
      if (lsuStall) stalls++;
      if (done) begin
        lat = n; s_rdata = readData; s_bus = busError;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    memRead = 0; memWrite = 0; dGnt = 0; dRvalid = 0;
  endtask

  task automatic misalign_case(input string tag, input logic st, input logic [2:0] lc,
                               input logic [1:0] sc, input logic [31:0] a);
    memWrite = st; memRead = ~st; loadCtrl = lc; storeCtrl = sc; address = a;
    @(negedge clk);
    check({tag, " stall"}, 32'(lsuStall), 32'd0);
    @(posedge clk); #1;
    memRead = 0; memWrite = 0;
    @(negedge clk);
    check({tag, " pulse"}, 32'(misaligned), 32'd1);
    check({tag, " noreq"}, 32'(dReq), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " pulse end"}, 32'(misaligned), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    sel8 = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst dReq", 32'(dReq), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst stall", 32'(lsuStall), 32'd0);
    check("rst readData", readData, 32'd0);
    check("rst dAddr", dAddr, 32'd0);
    check("rst dBe", 32'(dBe), 32'd0);
    check("rst dWdata", dWdata, 32'd0);
    @(posedge clk); #1;

    access(1'b1, LSU_LB, LSU_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, -1);
    check("sw dAddr", s_addr, 32'h100);
    check("sw dBe", 32'(s_be), 32'hF);
    check("sw dWe", 32'(s_we), 32'd1);
    check("sw dWdata", s_wdata, 32'hDEADBEEF);
    check("sw latency", 32'(lat), 32'd3);
    check("sw stall", 32'(stalls), 32'd2);

    access(1'b1, LSU_LB, LSU_SB, 32'h203, 32'h000000A5, 32'h0, 0, -1);
    check("sb dAddr", s_addr, 32'h200);
    check("sb dBe", 32'(s_be), 32'h8);
    check("sb dWdata", s_wdata, 32'hA5A5A5A5);
    check("sb latency", 32'(lat), 32'd3);

    access(1'b1, LSU_LB, LSU_SH, 32'h202, 32'h1234BEEF, 32'h0, 0, -1);
    check("sh dBe", 32'(s_be), 32'hC);
    check("sh dWdata", s_wdata, 32'hBEEFBEEF);

    access(1'b0, LSU_LB, LSU_SB, 32'h302, 32'h0, 32'h1280FF00, 0, 1);
    check("lb data", s_rdata, 32'hFFFFFF80);
    check("lb dBe", 32'(s_be), 32'h4);
    check("lb dWe", 32'(s_we), 32'd0);
    check("lb dAddr", s_addr, 32'h300);
    check("lb latency", 32'(lat), 32'd4);
    check("lb stall", 32'(stalls), 32'd3);

    access(1'b0, LSU_LBU, LSU_SB, 32'h302, 32'h0, 32'h1280FF00, 0, 1);
    check("lbu data", s_rdata, 32'h00000080);
    access(1'b0, LSU_LH, LSU_SB, 32'h302, 32'h0, 32'h1280FF00, 0, 1);
    check("lh hi data", s_rdata, 32'h00001280);
    check("lh hi dBe", 32'(s_be), 32'hC);
    access(1'b0, LSU_LH, LSU_SB, 32'h300, 32'h0, 32'h1280FF00, 0, 1);
    check("lh lo data", s_rdata, 32'hFFFFFF00);
    check("lh lo dBe", 32'(s_be), 32'h3);
    access(1'b0, LSU_LHU, LSU_SB, 32'h300, 32'h0, 32'h1280FF00, 0, 1);
    check("lhu data", s_rdata, 32'h0000FF00);
    access(1'b0, LSU_LW, LSU_SB, 32'h300, 32'h0, 32'h1280FF00, 0, 0);
    check("lw same-cycle data", s_rdata, 32'h1280FF00);
    check("lw same-cycle latency", 32'(lat), 32'd3);

    access(1'b1, LSU_LB, LSU_SW, 32'h10, 32'h1, 32'h0, 0, -1);
    check("readData hold", s_rdata, 32'h1280FF00);

    misalign_case("lw 0x101", 1'b0, LSU_LW, LSU_SB, 32'h101);
    misalign_case("lh 0x103", 1'b0, LSU_LH, LSU_SB, 32'h103);
    misalign_case("sw 0x102", 1'b1, LSU_LB, LSU_SW, 32'h102);
    misalign_case("rsvd load", 1'b0, 3'b011, LSU_SB, 32'h0);
    misalign_case("rsvd store", 1'b1, LSU_LB, 2'b11, 32'h0);

    access(1'b0, LSU_LW, LSU_SB, 32'h104, 32'h0, 32'hCAFEF00D, 5, 3);
    check("slow latency", 32'(lat), 32'd11);
    check("slow dReq cycles", 32'(reqs), 32'd6);
    check("slow addr stable", 32'(stable), 32'd1);
    check("slow dAddr", s_addr, 32'h104);
    check("slow data", s_rdata, 32'hCAFEF00D);
    check("slow busError", 32'(s_bus), 32'd0);

    memRead = 1; loadCtrl = LSU_LW; address = 32'h40;
    @(posedge clk); #1;
    dGnt = 1;
    @(posedge clk); #1;
    dGnt = 0;
    rst_n = 0; memRead = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("rst wait dReq", 32'(dReq), 32'd0);
    check("rst wait stall", 32'(lsuStall), 32'd0);
    @(posedge clk); #1;
    dRvalid = 1; dRdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray rvalid done", 32'(done), 32'd0);
      @(posedge clk); #1;
      dRvalid = 0;
    end
    check("stray rvalid data", readData, 32'd0);

    do_reset();
    sel8 = 1'b1;
    access(1'b0, LSU_LW, LSU_SB, 32'h8, 32'h0, 32'h12345678, 0, 1);
    check("t8 ok data", s_rdata, 32'h12345678);
    access(1'b0, LSU_LW, LSU_SB, 32'h8, 32'h0, 32'h12345678, 0, -1);
    check("t8 latency", 32'(lat), 32'd10);
    check("t8 busError", 32'(s_bus), 32'd1);
    check("t8 readData", s_rdata, 32'd0);
    @(negedge clk);
    check("t8 busError end", 32'(busError), 32'd0);
    check("t8 dReq", 32'(dReq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
